spmv_network_collector: RTL and testbench
=========================================

// Module: spmv_network_collector
// PURPOSE
//  Sink at the output of the SpMV reduction network; slave end of network_if (lanes a, b).
//  Merges runs of equal row id into one sum, lane a before lane b within a beat.
//  Emits each finished (row id, sum) on a valid/ready stream to the result writer.
//  A flush drains the open partial sum at end of matrix.
// PARAMETERS
//  ID_WIDTH   32  row id width; must match network_if id field
//  IN_WIDTH   32  network value width (signed two's complement)
//  ACC_WIDTH  48  accumulator/output width, >= IN_WIDTH
//  OUT_DEPTH  4   result FIFO depth, >= 2
// PORTS
//  clk         in   1          clock; all state on rising edge
//  rst         in   1          reset; asynchronous, active-high
//  in          network_if.slave  a/b {id,val,valid}; ready driven by this block
//  flush       in   1          single-cycle request to emit the open sum
//  out_valid   out  1          result available
//  out_ready   in   1          downstream accepts result
//  out_id      out  ID_WIDTH   row id of result
//  out_val     out  ACC_WIDTH  row sum
//  flush_done  out  1          one-cycle pulse: flush finished
//  sat_seen    out  1          sticky saturation flag
// BEHAVIOUR
//  Reset: acc_valid=0, acc_id=0, acc_val=0, FIFO empty, out_valid=0, flush_done=0,
//   sat_seen=0, flush_pending=0, in.ready=0 while rst high.
//  in.ready = (FIFO free slots >= 2); registered from FIFO occupancy, no comb path from out_ready.
//  Beat accepted when in.ready && (in.a.valid || in.b.valid); invalid lanes ignored.
//  Per accepted beat, entries processed in order a, b. For each entry e:
//   acc_valid && e.id==acc_id -> acc_val += sext(e.val);
//   else -> push {acc_id,acc_val} to FIFO if acc_valid; load acc_id=e.id, acc_val=sext(e.val), acc_valid=1.
//  At most 2 pushes per beat (hence the 2-slot ready rule). State updates in same cycle;
//   results visible at out_valid one cycle after the beat that closed the run.
//  Non-adjacent repeats of an id are not merged (two results for that id).
//  Arithmetic: sign-extend IN_WIDTH -> ACC_WIDTH; wraps modulo 2^ACC_WIDTH (see CONFIGURATION).
//  Output: FIFO head on out_id/out_val; pop on out_valid && out_ready; push/pop same cycle allowed
//   when full. out_id/out_val stable while out_valid && !out_ready.
//  Flush: flush sets flush_pending. Cycle with flush_pending && no beat accepted && FIFO free >= 1:
//   push acc if acc_valid, clear acc_valid, clear flush_pending, pulse flush_done.
//   Flush in same cycle as an accepted beat: beat processed first, drain next eligible cycle.
//   Flush with empty acc: flush_done pulses with no push. Flush while pending: ignored (single done).
//  Reset mid-operation: all state, FIFO contents and pending flush discarded immediately.
// CONFIGURATION
//  SPMV_COLLECTOR_SAT_EN defined: accumulate saturates to signed ACC_WIDTH min/max; any
//   clamp sets sat_seen (cleared only by rst).
//  Not defined: modulo wraparound; sat_seen tied 0.
// STRUCTURE
//  spmv_pkg: typedef net_entry_t {id,val}, typedef result_t {id,sum}, function sext_acc().
//  Sub-module spmv_collector_fifo: synchronous FIFO of result_t, depth OUT_DEPTH,
//   exposes free count for in.ready.
// TESTING
//  a={5,3},b={5,4}, then a={6,1} only, flush -> results (5,7),(6,1); flush_done once.
//  a={1,2},b={2,9} beat after acc id 0 open -> two pushes (0,..),(1,2); acc=(2,9).
//  out_ready=0 for 20 cycles with distinct ids each beat -> in.ready falls at free<2; no loss, order kept.
//  flush in same cycle as beat a={7,-3} with acc (7,10) -> single result (7,7), flush_done next cycle.
//  SAT_EN, ACC_WIDTH=IN_WIDTH=8: id 4 values 100,100 -> (4,127), sat_seen=1; without macro -> (4,-56).
//  rst asserted with 3 queued results and open acc -> out_valid=0 immediately; new run starts clean.

Source files
------------

// File: rtl/spmv_pkg.sv
// spmv_pkg: shared helpers for the SpMV network collector.
// Provides sign extension of network values to accumulator width.
package spmv_pkg;

  localparam int SEXT_W = 64;

  // Sign-extend the low w bits of v across all SEXT_W bits.
  function automatic logic [SEXT_W-1:0] sext_acc(
    input logic [SEXT_W-1:0] v,
    input int unsigned       w
  );
    logic [SEXT_W-1:0] r;
    r = $signed(v << (SEXT_W - w)) >>> (SEXT_W - w);
    return r;
  endfunction

endpackage

// File: rtl/network_if.sv
// network_if: reduction network output, two lanes (a, b) of {id,val,valid}.
// Master drives lanes; slave drives the shared ready.
interface network_if #(
  parameter int ID_WIDTH  = 32,
  parameter int VAL_WIDTH = 32
);
  logic                 a_valid;
  logic [ID_WIDTH-1:0]  a_id;
  logic [VAL_WIDTH-1:0] a_val;
  logic                 b_valid;
  logic [ID_WIDTH-1:0]  b_id;
  logic [VAL_WIDTH-1:0] b_val;
  logic                 ready;

  modport master (
    output a_valid, a_id, a_val,
    output b_valid, b_id, b_val,
    input  ready
  );

  modport slave (
    input  a_valid, a_id, a_val,
    input  b_valid, b_id, b_val,
    output ready
  );
endinterface

// File: rtl/spmv_collector_fifo.sv
// spmv_collector_fifo: result FIFO, up to two pushes and one pop per cycle.
// Ports: push_n/push0/push1 (push0 first), pop, head/valid, free (registered).
module spmv_collector_fifo #(
  parameter int W     = 80,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    push_n,
  input  logic [W-1:0]  push0,
  input  logic [W-1:0]  push1,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          valid,
  output logic [CW-1:0] free
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d, wr1;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr1   = inc(wr_q);
    wr_d  = wr_q;
    unique case (push_n)
      2'd1:    wr_d = wr1;
      2'd2:    wr_d = inc(wr1);
      default: wr_d = wr_q;
    endcase
    rd_d  = pop ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push_n) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem_q[wr_q] <= push0;
    if (push_n == 2'd2) mem_q[wr1]  <= push1;
  end

  assign head  = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign free  = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/spmv_network_collector.sv
// spmv_network_collector: merges equal-id runs from network_if lanes a,b into
// row sums, emitted on out_valid/out_ready; flush drains the open sum.
// Ports: clk, rst (async high), in (network_if.slave), flush, out_valid,
// out_ready, out_id, out_val, flush_done (pulse), sat_seen (sticky).
// Option: define SPMV_COLLECTOR_SAT_EN to saturate instead of wrap.
module spmv_network_collector
  import spmv_pkg::*;
#(
  parameter int ID_WIDTH  = 32,
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  network_if.slave             in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_WIDTH-1:0]  out_id,
  output logic [ACC_WIDTH-1:0] out_val,
  output logic                 flush_done,
  output logic                 sat_seen
);

  localparam int CW = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [IN_WIDTH-1:0] val;
  } net_entry_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic [ACC_WIDTH-1:0] sum;
  } result_t;

  typedef struct packed {
    logic                 v;
    logic [ID_WIDTH-1:0]  id;
    logic [ACC_WIDTH-1:0] val;
  } acc_t;

  typedef struct packed {
    acc_t    acc;
    logic    push;
    result_t res;
    logic    sat;
  } step_t;

  function automatic logic [ACC_WIDTH-1:0] widen(
    input logic [IN_WIDTH-1:0] v
  );
    return ACC_WIDTH'(sext_acc(SEXT_W'(v), IN_WIDTH));
  endfunction

  // Top bit of the result flags a clamp.
  function automatic logic [ACC_WIDTH:0] acc_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic [ACC_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
`ifdef SPMV_COLLECTOR_SAT_EN
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
`endif
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  // Fold one entry into the open run; a new id closes it.
  function automatic step_t step(input acc_t acc, input net_entry_t e);
    step_t              s;
    logic [ACC_WIDTH:0] r;
    s     = '0;
    s.acc = acc;
    if (acc.v && e.id == acc.id) begin
      r         = acc_add(acc.val, widen(e.val));
      s.acc.val = r[ACC_WIDTH-1:0];
      s.sat     = r[ACC_WIDTH];
    end else begin
      s.push = acc.v;
      s.res  = '{id: acc.id, sum: acc.val};
      s.acc  = '{v: 1'b1, id: e.id, val: widen(e.val)};
    end
    return s;
  endfunction

  acc_t          acc_q, acc_d;
  logic          pend_q, pend_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          sat_q, sat_d;
  net_entry_t    ent_a, ent_b;
  step_t         st_a, st_b;
  logic          accept, drain, pop;
  logic [1:0]    push_n;
  result_t       push0, push1, head;
  logic [CW-1:0] free;
  int            free_nxt;

  always_comb begin
    ent_a  = '{id: in.a_id, val: in.a_val};
    ent_b  = '{id: in.b_id, val: in.b_val};
    accept = ready_q && (in.a_valid || in.b_valid);
    drain  = pend_q && !accept && (free != '0);
    pop    = out_valid && out_ready;

    st_a     = '0;
    st_a.acc = acc_q;
    if (in.a_valid) st_a = step(acc_q, ent_a);
    st_b     = '0;
    st_b.acc = st_a.acc;
    if (in.b_valid) st_b = step(st_a.acc, ent_b);

    acc_d  = acc_q;
    pend_d = pend_q | flush;
    sat_d  = sat_q;
    push_n = 2'd0;
    push0  = '0;
    push1  = '0;

    if (accept) begin
      acc_d = st_b.acc;
      sat_d = sat_q | st_a.sat | st_b.sat;
      if (st_a.push) begin
        push0  = st_a.res;
        push1  = st_b.res;
        push_n = st_b.push ? 2'd2 : 2'd1;
      end else if (st_b.push) begin
        push0  = st_b.res;
        push_n = 2'd1;
      end
    end else if (drain) begin
      acc_d.v = 1'b0;
      pend_d  = 1'b0;
      if (acc_q.v) begin
        push0  = '{id: acc_q.id, sum: acc_q.val};
        push_n = 2'd1;
      end
    end

    done_d   = drain;
    // Ready looks at next-cycle occupancy so a beat never overflows.
    free_nxt = int'(free) - int'(push_n) + int'(pop);
    ready_d  = (free_nxt >= 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  spmv_collector_fifo #(
    .W     ($bits(result_t)),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_n (push_n),
    .push0  (push0),
    .push1  (push1),
    .pop    (pop),
    .head   (head),
    .valid  (out_valid),
    .free   (free)
  );

  assign in.ready   = ready_q;
  assign out_id     = head.id;
  assign out_val    = head.sum;
  assign flush_done = done_q;
  assign sat_seen   = sat_q;

endmodule

// File: tb/tb_spmv_network_collector.sv
// tb_spmv_network_collector: directed scoreboard bench for the collector.
// Small widths (IN 8, ACC 10) so wrap/saturation is reachable.
module tb_spmv_network_collector;

  localparam int IDW = 16;
  localparam int INW = 8;
  localparam int ACW = 10;
  localparam int DEP = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           out_ready = 1'b0;
  logic           out_valid, flush_done, sat_seen;
  logic [IDW-1:0] out_id;
  logic [ACW-1:0] out_val;

  network_if #(.ID_WIDTH(IDW), .VAL_WIDTH(INW)) nif ();

  spmv_network_collector #(
    .ID_WIDTH  (IDW),
    .IN_WIDTH  (INW),
    .ACC_WIDTH (ACW),
    .OUT_DEPTH (DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (nif),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_val    (out_val),
    .flush_done (flush_done),
    .sat_seen   (sat_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [ACW-1:0] val;
  } res_t;

  res_t exp_q[$];
  int   total  = 0;
  int   bad    = 0;
  int   fd_cnt = 0;
  logic hold   = 1'b0;
  res_t held;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic void expect_res(input int id, input int val);
    res_t r;
    r.id  = IDW'(id);
    r.val = ACW'(val);
    exp_q.push_back(r);
  endfunction

  // Monitor: pops the scoreboard on each handshake.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (flush_done) fd_cnt++;
        if (out_valid) begin
          if (hold) begin
            chk("hold_id", 32'(out_id), 32'(held.id));
            chk("hold_val", 32'(out_val), 32'(held.val));
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected: got id=%0h val=%0h want none",
                       out_id, out_val);
            end else begin
              e = exp_q.pop_front();
              chk("res_id", 32'(out_id), 32'(e.id));
              chk("res_val", 32'(out_val), 32'(e.val));
            end
            hold = 1'b0;
          end else begin
            hold    = 1'b1;
            held.id  = out_id;
            held.val = out_val;
          end
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  task automatic beat(input logic av, input int aid, input int aval,
                      input logic bv, input int bid, input int bval,
                      input logic fl);
    int n;
    n = 0;
    @(negedge clk);
    while (!nif.ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!nif.ready) begin
      total++;
      bad++;
      $display("FAIL beat_ready_timeout: got ready=0 want 1");
    end
    nif.a_valid = av;
    nif.a_id    = IDW'(aid);
    nif.a_val   = INW'(aval);
    nif.b_valid = bv;
    nif.b_id    = IDW'(bid);
    nif.b_val   = INW'(bval);
    flush       = fl;
    @(negedge clk);
    nif.a_valid = 1'b0;
    nif.b_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_fd(input string name, input int prev);
    int n;
    n = 0;
    while (fd_cnt <= prev && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(name, 32'(fd_cnt), 32'(prev + 1));
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 out_ready = v;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  int prev;

  initial begin
    nif.a_valid = 1'b0;
    nif.a_id    = '0;
    nif.a_val   = '0;
    nif.b_valid = 1'b0;
    nif.b_id    = '0;
    nif.b_val   = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(nif.ready), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_sat", 32'(sat_seen), 32'd0);
    rst = 1'b0;
    set_ready(1'b1);

    // Merge within and across beats, then flush.
    prev = fd_cnt;
    expect_res(5, 7);
    expect_res(6, 1);
    beat(1, 5, 3, 1, 5, 4, 0);
    beat(1, 6, 1, 0, 0, 0, 0);
    do_flush();
    wait_fd("fd_t1", prev);
    wait_drain("drain_t1");

    // Two pushes in one beat.
    prev = fd_cnt;
    expect_res(0, 5);
    expect_res(1, 2);
    expect_res(2, 9);
    beat(1, 0, 5, 0, 0, 0, 0);
    beat(1, 1, 2, 1, 2, 9, 0);
    do_flush();
    wait_fd("fd_t2", prev);
    wait_drain("drain_t2");

    // Backpressure: ready must drop, order kept.
    prev = fd_cnt;
    for (int i = 0; i < 8; i++) expect_res(10 + i, 10 + i);
    set_ready(1'b0);
    fork
      begin
        for (int i = 0; i < 8; i++) beat(1, 10 + i, 10 + i, 0, 0, 0, 0);
      end
      begin
        repeat (20) @(negedge clk);
        chk("bp_ready_low", 32'(nif.ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        set_ready(1'b1);
      end
    join
    do_flush();
    wait_fd("fd_t3", prev);
    wait_drain("drain_t3");

    // Flush with a beat; negative value is sign-extended.
    expect_res(7, 7);
    beat(1, 7, 10, 0, 0, 0, 0);
    prev = fd_cnt;
    beat(1, 7, -3, 0, 0, 0, 1);
    chk("fd_t4_early", 32'(flush_done), 32'd0);
    @(negedge clk);
    chk("fd_t4_pulse", 32'(flush_done), 32'd1);
    wait_drain("drain_t4");
    chk("fd_t4_count", 32'(fd_cnt), 32'(prev + 1));

    // Empty acc, flush held two cycles: one done, no result.
    prev = fd_cnt;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b0;
    wait_fd("fd_t5", prev);
    chk("t5_no_result", 32'(out_valid), 32'd0);

    // Overflow: 5 * 127 = 635 in a 10-bit signed accumulator.
    prev = fd_cnt;
`ifdef SPMV_COLLECTOR_SAT_EN
    expect_res(4, 511);
`else
    expect_res(4, 635);
`endif
    beat(1, 4, 127, 1, 4, 127, 0);
    beat(1, 4, 127, 1, 4, 127, 0);
    beat(1, 4, 127, 0, 0, 0, 0);
    do_flush();
    wait_fd("fd_t6", prev);
    wait_drain("drain_t6");
`ifdef SPMV_COLLECTOR_SAT_EN
    chk("sat_seen", 32'(sat_seen), 32'd1);
`else
    chk("sat_seen", 32'(sat_seen), 32'd0);
`endif

    // Reset with queued results and an open run.
    set_ready(1'b0);
    beat(1, 20, 1, 0, 0, 0, 0);
    beat(1, 21, 1, 0, 0, 0, 0);
    beat(1, 22, 1, 0, 0, 0, 0);
    beat(1, 23, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(nif.ready), 32'd0);
    chk("mid_rst_sat", 32'(sat_seen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_ready(1'b1);
    prev = fd_cnt;
    expect_res(30, 1);
    beat(1, 30, 1, 0, 0, 0, 0);
    do_flush();
    wait_fd("fd_t7", prev);
    wait_drain("drain_t7");
    chk("fd_total", 32'(fd_cnt), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
